// File: rtl/oci_dct_packer.sv
// OCI DCT producer: packs 2-bit trace symbols into 30-bit frames and hands them
// to the frame sink through a single valid/ready output register.
module oci_dct_packer #(
  parameter int SYM_W = 2,
  parameter int SLOTS = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sym_valid,
  input  logic [SYM_W-1:0]       sym_data,
  output logic                   sym_ready,
  input  logic                   flush,
  input  logic                   test_ending,
  output logic [SYM_W*SLOTS-1:0] dct_buffer,
  output logic [3:0]             dct_count,
  output logic                   frm_valid,
  input  logic                   frm_ready,
  output logic [SYM_W*SLOTS-1:0] frm_data,
  output logic [3:0]             frm_count,
  output logic                   test_has_ended
);
  localparam int BUF_W = SYM_W * SLOTS;
  localparam logic [3:0] FULL = 4'(SLOTS);

  typedef enum logic [1:0] {ST_FILL, ST_FLUSH, ST_DRAIN, ST_ENDED} state_t;

  state_t           r_state;
  logic [BUF_W-1:0] r_buf;
  logic [3:0]       r_cnt;
  logic             r_frm_valid;
  logic [BUF_W-1:0] r_frm_data;
  logic [3:0]       r_frm_count;
  logic             r_ended;

  logic w_accept;
  logic w_asm_rdy;
  logic w_slot_free;
  logic w_handoff;

  // Only FILL takes symbols, and never once the assembly is full.
  assign sym_ready   = !reset && (r_state == ST_FILL) && (r_cnt != FULL);
  assign w_accept    = sym_valid && sym_ready;
  assign w_slot_free = !r_frm_valid || frm_ready;

  always_comb begin
    w_asm_rdy = 1'b0;
    case (r_state)
      ST_FILL:  w_asm_rdy = (r_cnt == FULL);
      ST_FLUSH: w_asm_rdy = (r_cnt != 4'd0);
      ST_DRAIN: w_asm_rdy = (r_cnt != 4'd0);
      default:  w_asm_rdy = 1'b0;
    endcase
  end

  assign w_handoff = w_asm_rdy && w_slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FILL;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_frm_valid <= 1'b0;
      r_frm_data  <= '0;
      r_frm_count <= '0;
      r_ended     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf <= {r_buf[BUF_W-SYM_W-1:0], sym_data};
        r_cnt <= r_cnt + 4'd1;
      end
      // Accept and handoff are mutually exclusive: a ready assembly blocks sym_ready.
      if (w_handoff) begin
        r_frm_data  <= r_buf;
        r_frm_count <= r_cnt;
        r_frm_valid <= 1'b1;
        r_buf       <= '0;
        r_cnt       <= '0;
      end else if (r_frm_valid && frm_ready) begin
        r_frm_valid <= 1'b0;
      end
      if (r_state == ST_ENDED)
        r_ended <= 1'b1;

      case (r_state)
        ST_FILL: begin
          if (test_ending)  r_state <= ST_DRAIN;
          else if (flush)   r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (test_ending)                     r_state <= ST_DRAIN;
          else if (r_cnt == 4'd0 || w_handoff) r_state <= ST_FILL;
        end
        ST_DRAIN: begin
          // Final partial frame first, then wait for the sink to take the last one.
          if (r_cnt == 4'd0 && w_slot_free) r_state <= ST_ENDED;
        end
        default: r_state <= ST_ENDED;
      endcase
    end
  end

  assign dct_buffer     = r_buf;
  assign dct_count      = r_cnt;
  assign frm_valid      = r_frm_valid;
  assign frm_data       = r_frm_data;
  assign frm_count      = r_frm_count;
  assign test_has_ended = r_ended;

endmodule

// File: tb/tb_oci_dct_packer.sv
// Scoreboard bench for oci_dct_packer: frames expected from accepted symbols are
// queued by the driver and popped by a monitor on each frame transfer.
module tb_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_data = 2'd0;
  logic        sym_ready;
  logic        flush = 1'b0;
  logic        test_ending = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frm_valid;
  logic        frm_ready = 1'b0;
  logic [29:0] frm_data;
  logic [3:0]  frm_count;
  logic        test_has_ended;

  oci_dct_packer dut (
    .clk(clk), .reset(reset),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .flush(flush), .test_ending(test_ending),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_data(frm_data), .frm_count(frm_count),
    .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  typedef struct {logic [29:0] d; logic [3:0] c;} frm_t;
  frm_t exp_q[$];

  int total = 0;
  int bad   = 0;

  logic        b_rst = 1'b1;
  logic        rdy = 1'b0;
  logic        te_lvl = 1'b0;
  logic        acc;
  logic [29:0] m_buf = '0;
  int          m_cnt = 0;
  int          s = 0;

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_model();
    frm_t f;
    f.d = m_buf;
    f.c = 4'(m_cnt);
    exp_q.push_back(f);
    m_buf = '0;
    m_cnt = 0;
  endtask

  // One clock: drive at negedge, note acceptance, then advance the model after posedge.
  task automatic cyc(input logic v, input logic [1:0] d, input logic fl, input logic te);
    @(negedge clk);
    reset = b_rst; frm_ready = rdy;
    sym_valid = v; sym_data = d; flush = fl; test_ending = te;
    #1 acc = v && sym_ready;
    @(posedge clk);
    if (b_rst) begin
      m_buf = '0; m_cnt = 0; exp_q.delete();
    end else begin
      if (acc) begin
        m_buf = {m_buf[27:0], d};
        m_cnt++;
        if (m_cnt == 15) push_model();
      end
      if ((fl || te) && m_cnt != 0) push_model();
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 2'd0, 1'b0, te_lvl);
  endtask

  task automatic send_n(input int n, input int budget, output int got);
    got = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      cyc(1'b1, 2'(s), 1'b0, te_lvl);
      if (acc) begin got++; s++; end
    end
  endtask

  // Frame monitor: compares each transfer to the queue and checks hold stability.
  logic        held = 1'b0;
  logic [33:0] prev = '0;
  always @(negedge clk) begin
    #2;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (frm_valid) begin
        if (held) chk("hold_stable", {frm_count, frm_data}, prev);
        if (frm_ready) begin
          if (exp_q.size() == 0) chk("spurious_frame", {33'd0, frm_valid}, 34'd0);
          else begin
            frm_t e;
            e = exp_q.pop_front();
            chk("frm_data", {4'd0, frm_data}, {4'd0, e.d});
            chk("frm_count", {30'd0, frm_count}, {30'd0, e.c});
          end
        end
      end
      held = frm_valid && !frm_ready;
      prev = {frm_count, frm_data};
    end
  end

  initial begin
    int got;
    // Reset state
    b_rst = 1'b1; rdy = 1'b1;
    idle(2);
    #1;
    chk("rst_sym_ready", {33'd0, sym_ready}, 34'd0);
    chk("rst_outs", {dct_count, dct_buffer}, 34'd0);
    chk("rst_frm", {frm_valid, test_has_ended, frm_count, frm_data[27:0]}, 34'd0);
    b_rst = 1'b0;
    idle(1);

    // 1: full frame at full rate
    s = 0;
    send_n(15, 15, got);
    chk("t1_accepts", 34'(got), 34'd15);
    idle(1);
    #1;
    chk("t1_valid", {33'd0, frm_valid}, 34'd1);
    chk("t1_data", {4'd0, frm_data}, {4'd0, 30'h06C6C6C6});
    chk("t1_count", {30'd0, frm_count}, 34'd15);
    chk("t1_dct_count", {30'd0, dct_count}, 34'd0);
    idle(2);

    // 2: partial frame via flush
    s = 1;
    send_n(3, 5, got);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    #1 chk("t2_rdy_flush", {33'd0, sym_ready}, 34'd0);
    chk("t2_count_before", {30'd0, dct_count}, 34'd3);
    idle(1);
    #1 chk("t2_frame", {frm_valid, frm_count, frm_data[28:0]}, {1'b1, 4'd3, 29'h1B});
    chk("t2_rdy_back", {33'd0, sym_ready}, 34'd1);
    idle(2);

    // 3: empty flush
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    #1 chk("t3_rdy_flush", {33'd0, sym_ready}, 34'd0);
    idle(1);
    #1 chk("t3_rdy_back", {33'd0, sym_ready}, 34'd1);
    chk("t3_no_frame", {33'd0, frm_valid}, 34'd0);

    // 4: backpressure fills both the output slot and the assembly
    rdy = 1'b0;
    send_n(40, 35, got);
    chk("t4_accepts", 34'(got), 34'd30);
    #1 chk("t4_stall", {29'd0, sym_ready, dct_count}, {29'd0, 1'b0, 4'd15});
    chk("t4_valid", {33'd0, frm_valid}, 34'd1);
    rdy = 1'b1;
    idle(1);
    #1 chk("t4_b2b", {29'd0, frm_valid, frm_count}, {29'd0, 1'b1, 4'd15});
    idle(1);
    #1 chk("t4_drained", {33'd0, frm_valid}, 34'd0);
    send_n(10, 12, got);
    chk("t4_resume", 34'(got), 34'd10);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    idle(3);

    // 5: end-of-test drain under backpressure
    send_n(5, 6, got);
    rdy = 1'b0; te_lvl = 1'b1;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    #1 chk("t5_rdy", {33'd0, sym_ready}, 34'd0);
    idle(2);
    #1 chk("t5_partial", {29'd0, frm_valid, frm_count}, {29'd0, 1'b1, 4'd5});
    chk("t5_not_ended", {33'd0, test_has_ended}, 34'd0);
    rdy = 1'b1;
    idle(1);
    #1 chk("t5_ended_lag", {33'd0, test_has_ended}, 34'd0);
    idle(1);
    #1 chk("t5_ended", {33'd0, test_has_ended}, 34'd1);
    te_lvl = 1'b0;
    cyc(1'b1, 2'd2, 1'b1, 1'b0);
    idle(3);
    #1 chk("t5_sticky", {32'd0, test_has_ended, sym_ready}, {32'd0, 1'b1, 1'b0});

    // 6: reset mid-operation discards everything
    b_rst = 1'b1; idle(1); b_rst = 1'b0;
    rdy = 1'b0;
    send_n(24, 30, got);
    chk("t6_accepts", 34'(got), 34'd24);
    #1 chk("t6_pre", {29'd0, frm_valid, dct_count}, {29'd0, 1'b1, 4'd9});
    b_rst = 1'b1; idle(1);
    #1 chk("t6_rst_a", {frm_valid, test_has_ended, dct_count, dct_buffer[27:0]}, 34'd0);
    chk("t6_rst_b", {frm_count, frm_data}, 34'd0);
    b_rst = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      idle(1);
      #1 chk("t6_no_frame", {33'd0, frm_valid}, 34'd0);
    end

    chk("queue_empty", 34'(exp_q.size()), 34'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
